// File: rtl/adma_desc_fetch_pkg.sv
// adma_desc_fetch_pkg: shared state, descriptor-field and error encodings for the ADMA2 descriptor walker
package adma_desc_fetch_pkg;
  typedef enum logic [8:0] {
    ST_IDLE      = 9'b000000001,
    ST_FETCH0    = 9'b000000010,
    ST_FETCH1    = 9'b000000100,
    ST_FETCH2    = 9'b000001000,
    ST_FETCH3    = 9'b000010000,
    ST_DECODE    = 9'b000100000,
    ST_TFR_START = 9'b001000000,
    ST_TFR_ARM   = 9'b010000000,
    ST_TFR_WAIT  = 9'b100000000
  } state_t;
  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } act_t;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_VALID   = 2'b01,
    ERR_ALIGN   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;
  localparam int W0_VALID = 0;
  localparam int W0_END = 1;
  localparam int W0_INT = 2;
  localparam int W0_ACT = 4;
  localparam int W0_LEN = 16;
  localparam int DESC_BYTES_DEF = 12;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic        irq;
    act_t        act;
    logic [15:0] length;
  } attr_t;
endpackage

// File: rtl/adma_desc_fetch_if.sv
// adma_desc_fetch_if: descriptor RAM read port and transfer-engine handshake
interface adma_desc_fetch_if;
  logic        ram_read;
  logic [63:0] ram_address;
  logic [31:0] data_from_ram;
  logic        xfer_start;
  logic        xfer_direction;
  logic [63:0] xfer_address;
  logic [15:0] xfer_length;
  logic        xfer_tfc;
  modport master (
    output ram_read, ram_address, xfer_start, xfer_direction, xfer_address, xfer_length,
    input  data_from_ram, xfer_tfc
  );
  modport slave (
    input  ram_read, ram_address, xfer_start, xfer_direction, xfer_address, xfer_length,
    output data_from_ram, xfer_tfc
  );
endinterface

// File: rtl/adma_desc_fetch_attr_decode.sv
// adma_desc_fetch_attr_decode: splits descriptor word 0 into valid/end/int/act/length
module adma_desc_fetch_attr_decode
  import adma_desc_fetch_pkg::*;
(
  input  logic [31:0] w0,
  output attr_t       attr
);
  logic unused_bits;
  assign unused_bits = ^{w0[15:6], w0[3]};
  assign attr.valid = w0[W0_VALID];
  assign attr.last = w0[W0_END];
  assign attr.irq = w0[W0_INT];
  assign attr.act = act_t'(w0[W0_ACT +: 2]);
  assign attr.length = w0[W0_LEN +: 16];
endmodule

// File: rtl/adma_desc_fetch.sv
// adma_desc_fetch: ADMA2 descriptor table walker that launches one engine transfer per TRAN descriptor
// Optional transfer watchdog enabled by defining ADMA_TFR_TIMEOUT_EN.
module adma_desc_fetch
  import adma_desc_fetch_pkg::*;
#(
  parameter int DESC_BYTES = DESC_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              adma_start,
  input  logic              adma_stop,
  input  logic              direction,
  input  logic [63:0]       desc_base,
  adma_desc_fetch_if.master bus,
  output logic              adma_busy,
  output logic              adma_done,
  output logic              adma_int,
  output logic              adma_error,
  output logic [1:0]        error_code
);
  state_t state;
  logic [63:0] ptr, addr, nxt;
  logic [31:0] w0;
  logic stop_q, fetching, in_tfr;
  attr_t attr;
  adma_desc_fetch_attr_decode u_attr (.w0(w0), .attr(attr));
  assign nxt = ptr + 64'(DESC_BYTES);
  assign adma_busy = state != ST_IDLE;
  assign fetching = state inside {ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_FETCH3, ST_DECODE};
  assign in_tfr = state inside {ST_TFR_START, ST_TFR_ARM, ST_TFR_WAIT};
`ifdef ADMA_TFR_TIMEOUT_EN
  logic [15:0] cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
  // A stop during a transfer is parked here until the engine reports completion.
  always_ff @(posedge CLK) begin
    bus.ram_read <= 1'b0;
    bus.xfer_start <= 1'b0;
    adma_done <= 1'b0;
    adma_int <= 1'b0;
    stop_q <= in_tfr && (stop_q || adma_stop);
    if (!RESET_L) begin
      state <= ST_IDLE;
      ptr <= '0;
      addr <= '0;
      w0 <= '0;
      stop_q <= 1'b0;
      bus.ram_address <= '0;
      bus.xfer_direction <= 1'b0;
      bus.xfer_address <= '0;
      bus.xfer_length <= '0;
      adma_error <= 1'b0;
      error_code <= ERR_NONE;
`ifdef ADMA_TFR_TIMEOUT_EN
      cnt <= '0;
`endif
    end else if (adma_stop && fetching) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (adma_start) begin
            ptr <= desc_base;
            bus.xfer_direction <= direction;
            adma_error <= desc_base[1:0] != 2'b00;
            error_code <= desc_base[1:0] != 2'b00 ? ERR_ALIGN : ERR_NONE;
            if (desc_base[1:0] == 2'b00) begin
              state <= ST_FETCH0;
              bus.ram_read <= 1'b1;
              bus.ram_address <= desc_base;
            end
          end
        ST_FETCH0: begin
          state <= ST_FETCH1;
          bus.ram_read <= 1'b1;
          bus.ram_address <= ptr + 64'd4;
        end
        ST_FETCH1: begin
          w0 <= bus.data_from_ram;
          state <= ST_FETCH2;
          bus.ram_read <= 1'b1;
          bus.ram_address <= ptr + 64'd8;
        end
        ST_FETCH2: begin
          addr[31:0] <= bus.data_from_ram;
          state <= ST_FETCH3;
        end
        ST_FETCH3: begin
          addr[63:32] <= bus.data_from_ram;
          state <= ST_DECODE;
        end
        ST_DECODE:
          if (!attr.valid) begin
            state <= ST_IDLE;
            adma_error <= 1'b1;
            error_code <= ERR_VALID;
          end else if (attr.act == ACT_LINK) begin
            ptr <= addr;
            if (addr[1:0] != 2'b00) begin
              state <= ST_IDLE;
              adma_error <= 1'b1;
              error_code <= ERR_ALIGN;
            end else begin
              state <= ST_FETCH0;
              bus.ram_read <= 1'b1;
              bus.ram_address <= addr;
            end
          end else if (attr.act == ACT_TRAN) begin
            state <= ST_TFR_START;
            bus.xfer_start <= 1'b1;
            bus.xfer_address <= addr;
            bus.xfer_length <= attr.length;
          end else if (attr.last) begin
            state <= ST_IDLE;
            adma_done <= 1'b1;
          end else begin
            ptr <= nxt;
            state <= ST_FETCH0;
            bus.ram_read <= 1'b1;
            bus.ram_address <= nxt;
          end
        ST_TFR_START: state <= ST_TFR_ARM;
        ST_TFR_ARM: begin
          state <= ST_TFR_WAIT;
`ifdef ADMA_TFR_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        ST_TFR_WAIT:
          if (bus.xfer_tfc) begin
            adma_int <= attr.irq;
            if (stop_q || adma_stop) begin
              state <= ST_IDLE;
            end else if (attr.last) begin
              state <= ST_IDLE;
              adma_done <= 1'b1;
            end else begin
              ptr <= nxt;
              state <= ST_FETCH0;
              bus.ram_read <= 1'b1;
              bus.ram_address <= nxt;
            end
          end
`ifdef ADMA_TFR_TIMEOUT_EN
          else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state <= ST_IDLE;
            adma_error <= 1'b1;
            error_code <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 16'd1;
          end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adma_desc_fetch.sv
// tb_adma_desc_fetch: directed scoreboard bench for adma_desc_fetch with RAM and transfer-engine models
module tb_adma_desc_fetch;
  typedef struct packed {
    logic [63:0] a;
    logic [15:0] l;
    logic        d;
  } xfer_t;
  localparam logic [1:0] NOP = 2'b00, TRAN = 2'b10, LINK = 2'b11;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic CLK = 1'b0, RESET_L = 1'b0, adma_start = 1'b0, adma_stop = 1'b0, direction = 1'b0, hold = 1'b0;
  logic [63:0] desc_base = '0;
  logic adma_busy, adma_done, adma_int, adma_error;
  logic [1:0] error_code;
  int checks = 0, errors = 0, eng_lat = 4, eng_cnt = 0;
  int nstart = 0, ndone = 0, nint = 0, nboth = 0;
  int b_start = 0, b_done = 0, b_int = 0, b_both = 0, rf = 0, rx = 0;
  logic [31:0] mem [logic [63:0]];
  logic [63:0] fq[$], obs_f[$];
  xfer_t xq[$], obs_x[$];

  adma_desc_fetch_if bus ();
  adma_desc_fetch #(.DESC_BYTES(12), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .adma_start(adma_start), .adma_stop(adma_stop),
    .direction(direction), .desc_base(desc_base), .bus(bus), .adma_busy(adma_busy),
    .adma_done(adma_done), .adma_int(adma_int), .adma_error(adma_error), .error_code(error_code)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    bus.data_from_ram <= !bus.ram_read ? 32'hDEAD_BEEF :
                         mem.exists(bus.ram_address) ? mem[bus.ram_address] : 32'h0;
    eng_cnt <= bus.xfer_start ? eng_lat : (eng_cnt > 0 ? eng_cnt - 1 : 0);
  end
  assign bus.xfer_tfc = eng_cnt == 0 && !hold;

  always @(negedge CLK) if (RESET_L) begin
    if (bus.ram_read) obs_f.push_back(bus.ram_address);
    if (bus.xfer_start) obs_x.push_back({bus.xfer_address, bus.xfer_length, bus.xfer_direction});
    nstart += int'(bus.xfer_start);
    ndone += int'(adma_done);
    nint += int'(adma_int);
    nboth += int'(adma_done && adma_int);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  function automatic logic [31:0] dw0(input logic [15:0] len, input logic [1:0] act,
                                      input logic irq, input logic last, input logic valid);
    return {len, 10'b0, act, 1'b0, irq, last, valid};
  endfunction

  task automatic put(input logic [63:0] at, input logic [31:0] w, input logic [63:0] a);
    mem[at] = w;
    mem[at + 64'd4] = a[31:0];
    mem[at + 64'd8] = a[63:32];
  endtask

  task automatic exp_desc(input logic [63:0] at);
    fq.push_back(at);
    fq.push_back(at + 64'd4);
    fq.push_back(at + 64'd8);
  endtask

  task automatic go(input logic [63:0] base, input logic dir);
    b_start = nstart;
    b_done = ndone;
    b_int = nint;
    b_both = nboth;
    @(negedge CLK);
    desc_base = base;
    direction = dir;
    adma_start = 1'b1;
    @(negedge CLK);
    adma_start = 1'b0;
  endtask

  task automatic wait_idle(input string t, input int max, output int n);
    n = 0;
    while (adma_busy && n < max) begin
      @(negedge CLK);
      n++;
    end
    chk({t, "_idle"}, 64'(adma_busy), 64'(0));
    repeat (2) @(negedge CLK);
    #1;
  endtask

  task automatic ev(input string t, input int s, input int d, input int i, input int b);
    chk({t, "_starts"}, 64'(nstart - b_start), 64'(s));
    chk({t, "_dones"}, 64'(ndone - b_done), 64'(d));
    chk({t, "_ints"}, 64'(nint - b_int), 64'(i));
    chk({t, "_int_with_done"}, 64'(nboth - b_both), 64'(b));
  endtask

  task automatic drain(input string t);
    logic [63:0] e;
    xfer_t x, o;
    while (fq.size() > 0) begin
      e = fq.pop_front();
      chk({t, "_fetch_addr"}, rf < obs_f.size() ? obs_f[rf] : NONE, e);
      rf++;
    end
    chk({t, "_fetch_count"}, 64'(obs_f.size()), 64'(rf));
    while (xq.size() > 0) begin
      x = xq.pop_front();
      o = rx < obs_x.size() ? obs_x[rx] : xfer_t'('1);
      chk({t, "_xfer_addr"}, o.a, x.a);
      chk({t, "_xfer_len"}, 64'(o.l), 64'(x.l));
      chk({t, "_xfer_dir"}, 64'(o.d), 64'(x.d));
      rx++;
    end
    chk({t, "_xfer_count"}, 64'(obs_x.size()), 64'(rx));
  endtask

  task automatic err_is(input string t, input logic [1:0] code);
    chk({t, "_error_code"}, 64'(error_code), 64'(code));
    chk({t, "_adma_error"}, 64'(adma_error), 64'(code != 2'b00));
  endtask

  initial begin
    int n;
    put(64'h0, dw0(16'h0200, TRAN, 1'b0, 1'b1, 1'b1), 64'h1000);
    put(64'h100, dw0(16'h0040, TRAN, 1'b0, 1'b0, 1'b1), 64'h0000_0003_0000_4000);
    put(64'h10C, dw0(16'h0000, NOP, 1'b0, 1'b0, 1'b1), 64'h0);
    put(64'h118, dw0(16'h0000, TRAN, 1'b1, 1'b1, 1'b1), 64'h5000);
    put(64'h200, dw0(16'h0000, LINK, 1'b1, 1'b1, 1'b1), 64'h2000);
    put(64'h2000, dw0(16'h0008, TRAN, 1'b0, 1'b1, 1'b1), 64'h7000);
    put(64'h300, dw0(16'h0000, LINK, 1'b0, 1'b0, 1'b1), 64'h2002);
    put(64'h400, dw0(16'h0010, TRAN, 1'b0, 1'b1, 1'b0), 64'h8000);
    put(64'hFFFF_FFFF_FFFF_FFF4, dw0(16'h0000, NOP, 1'b0, 1'b0, 1'b1), 64'h0);

    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(adma_busy), 64'(0));
    chk("rst_ram_read", 64'(bus.ram_read), 64'(0));
    chk("rst_ram_address", bus.ram_address, 64'h0);
    chk("rst_xfer_start", 64'(bus.xfer_start), 64'(0));
    chk("rst_done", 64'(adma_done), 64'(0));
    err_is("rst", 2'b00);
    RESET_L = 1'b1;

    exp_desc(64'h0);
    xq.push_back({64'h1000, 16'h0200, 1'b1});
    go(64'h0, 1'b1);
    chk("t1_busy", 64'(adma_busy), 64'(1));
    wait_idle("t1", 200, n);
    ev("t1", 1, 1, 0, 0);
    err_is("t1", 2'b00);
    drain("t1");

    exp_desc(64'h100);
    exp_desc(64'h10C);
    exp_desc(64'h118);
    xq.push_back({64'h0000_0003_0000_4000, 16'h0040, 1'b0});
    xq.push_back({64'h5000, 16'h0000, 1'b0});
    go(64'h100, 1'b0);
    wait_idle("t2", 300, n);
    ev("t2", 2, 1, 1, 1);
    drain("t2");

    exp_desc(64'h200);
    exp_desc(64'h2000);
    xq.push_back({64'h7000, 16'h0008, 1'b1});
    go(64'h200, 1'b1);
    wait_idle("t3_link", 200, n);
    ev("t3_link", 1, 1, 0, 0);
    err_is("t3_link", 2'b00);
    drain("t3_link");

    exp_desc(64'h300);
    go(64'h300, 1'b0);
    wait_idle("t3_badlink", 100, n);
    ev("t3_badlink", 0, 0, 0, 0);
    err_is("t3_badlink", 2'b10);
    drain("t3_badlink");

    go(64'h6, 1'b0);
    chk("badbase_busy", 64'(adma_busy), 64'(0));
    err_is("badbase", 2'b10);
    drain("badbase");

    exp_desc(64'h400);
    go(64'h400, 1'b0);
    wait_idle("t4", 100, n);
    ev("t4", 0, 0, 0, 0);
    err_is("t4", 2'b01);
    drain("t4");

    exp_desc(64'h0);
    xq.push_back({64'h1000, 16'h0200, 1'b0});
    go(64'h0, 1'b0);
    err_is("t4_clear", 2'b00);
    wait_idle("t4_clear", 200, n);
    ev("t4_clear", 1, 1, 0, 0);
    drain("t4_clear");

    exp_desc(64'hFFFF_FFFF_FFFF_FFF4);
    exp_desc(64'h0);
    xq.push_back({64'h1000, 16'h0200, 1'b1});
    go(64'hFFFF_FFFF_FFFF_FFF4, 1'b1);
    wait_idle("wrap", 200, n);
    ev("wrap", 1, 1, 0, 0);
    err_is("wrap", 2'b00);
    drain("wrap");

    exp_desc(64'h0);
    go(64'h0, 1'b0);
    repeat (2) @(negedge CLK);
    chk("t5_in_fetch2", bus.ram_address, 64'h8);
    adma_stop = 1'b1;
    @(negedge CLK);
    adma_stop = 1'b0;
    chk("t5_fetch_stop_busy", 64'(adma_busy), 64'(0));
    repeat (2) @(negedge CLK);
    #1;
    ev("t5_fetch_stop", 0, 0, 0, 0);
    err_is("t5_fetch_stop", 2'b00);
    drain("t5_fetch_stop");

    eng_lat = 20;
    exp_desc(64'h118);
    xq.push_back({64'h5000, 16'h0000, 1'b1});
    go(64'h118, 1'b1);
    n = 0;
    while (nstart == b_start && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("t5_wait_started", 64'(nstart - b_start), 64'(1));
    @(negedge CLK);
    adma_stop = 1'b1;
    @(negedge CLK);
    adma_stop = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5_wait_still_busy", 64'(adma_busy), 64'(1));
    wait_idle("t5_wait_stop", 100, n);
    ev("t5_wait_stop", 1, 0, 1, 0);
    err_is("t5_wait_stop", 2'b00);
    drain("t5_wait_stop");
    eng_lat = 4;

    hold = 1'b1;
    exp_desc(64'h0);
    xq.push_back({64'h1000, 16'h0200, 1'b0});
    go(64'h0, 1'b0);
`ifdef ADMA_TFR_TIMEOUT_EN
    wait_idle("t6", 100, n);
    chk("t6_timeout_cycles", 64'(n), 64'(23));
    ev("t6", 1, 0, 0, 0);
    err_is("t6", 2'b11);
    hold = 1'b0;
`else
    repeat (1000) @(negedge CLK);
    chk("t6_busy_1000", 64'(adma_busy), 64'(1));
    err_is("t6_waiting", 2'b00);
    hold = 1'b0;
    wait_idle("t6", 100, n);
    ev("t6", 1, 1, 0, 0);
    err_is("t6", 2'b00);
`endif
    drain("t6");

    hold = 1'b1;
    exp_desc(64'h0);
    go(64'h0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET_L = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", 64'(adma_busy), 64'(0));
    chk("midrst_ram_read", 64'(bus.ram_read), 64'(0));
    chk("midrst_ram_address", bus.ram_address, 64'h0);
    RESET_L = 1'b1;
    hold = 1'b0;
    repeat (5) @(negedge CLK);
    chk("midrst_stays_idle", 64'(adma_busy), 64'(0));
    ev("midrst", 0, 0, 0, 0);
    drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
